// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Two-requester register-file writeback arbiter (ALU, memory
//                load) with round-robin priority. Also keeps a pending-write
//                scoreboard with hazard detection and a sticky error for
//                double reservation.
//                Optional macro RF_WB_BYPASS_EN forwards the in-flight
//                writeback data to the read ports and masks the matching
//                hazard.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    // ALU writeback requester
    input  logic        a_valid,
    input  logic [3:0]  a_dest,
    input  logic [31:0] a_data,
    output logic        a_ready,
    // Memory-load writeback requester
    input  logic        m_valid,
    input  logic [3:0]  m_dest,
    input  logic [31:0] m_data,
    output logic        m_ready,
    // Issue-stage reservation
    input  logic        rsv_valid,
    input  logic [3:0]  rsv_dest,
    // Register file read path
    input  logic [3:0]  src0,
    input  logic [3:0]  src1,
    input  logic [31:0] rd0_in,
    input  logic [31:0] rd1_in,
    output logic [31:0] rd0_out,
    output logic [31:0] rd1_out,
    // Register file write port
    output logic        rf_we,
    output logic [3:0]  rf_dest,
    output logic [31:0] rf_data,
    // Scoreboard
    output logic [15:0] busy,
    output logic        hazard,
    output logic        rsv_err
);

    // Priority pointer encoding: which requester wins when both are valid
    localparam logic [0:0] c_PRI_ALU = 1'b0;
    localparam logic [0:0] c_PRI_MEM = 1'b1;

    logic [0:0]  r_ptr;
    logic        w_grant_a;
    logic        w_grant_m;
    logic [15:0] w_busy_clr;
    logic [15:0] w_busy_set;
    logic        w_rsv_conflict;
    logic        w_byp0;
    logic        w_byp1;

    // Grant decode: lone valid always wins, contention resolved by pointer;
    // nothing is granted while reset is asserted
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_m = 1'b0;
        if (!reset) begin
            if (a_valid && m_valid) begin
                w_grant_a = (r_ptr == c_PRI_ALU);
                w_grant_m = (r_ptr == c_PRI_MEM);
            end else begin
                w_grant_a = a_valid;
                w_grant_m = m_valid;
            end
        end
    end

    assign a_ready = w_grant_a;
    assign m_ready = w_grant_m;

    // Round-robin pointer: after any grant the other requester gets priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= c_PRI_ALU;
        end else if (w_grant_a) begin
            r_ptr <= c_PRI_MEM;
        end else if (w_grant_m) begin
            r_ptr <= c_PRI_ALU;
        end
    end

    // Writeback register: the winner's dest/data are presented for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we   <= 1'b0;
            rf_dest <= 4'd0;
            rf_data <= 32'd0;
        end else begin
            rf_we <= w_grant_a | w_grant_m;
            if (w_grant_a) begin
                rf_dest <= a_dest;
                rf_data <= a_data;
            end else if (w_grant_m) begin
                rf_dest <= m_dest;
                rf_data <= m_data;
            end
        end
    end

    // One-hot set/clear vectors for the scoreboard update
    always_comb begin
        w_busy_clr = 16'd0;
        w_busy_set = 16'd0;
        if (rf_we) begin
            w_busy_clr[rf_dest] = 1'b1;
        end
        if (rsv_valid) begin
            w_busy_set[rsv_dest] = 1'b1;
        end
    end

    // A reservation is only legal on a free register or one retiring now
    assign w_rsv_conflict = rsv_valid && busy[rsv_dest] && !w_busy_clr[rsv_dest];

    // Scoreboard: set has precedence over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 16'd0;
        end else begin
            busy <= (busy & ~w_busy_clr) | w_busy_set;
        end
    end

    // Sticky reservation error, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rsv_err <= 1'b0;
        end else if (w_rsv_conflict) begin
            rsv_err <= 1'b1;
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Forward the write in flight when it targets a register being read
    assign w_byp0 = rf_we && (rf_dest == src0);
    assign w_byp1 = rf_we && (rf_dest == src1);
`else
    assign w_byp0 = 1'b0;
    assign w_byp1 = 1'b0;
`endif

    assign rd0_out = w_byp0 ? rf_data : rd0_in;
    assign rd1_out = w_byp1 ? rf_data : rd1_in;
    assign hazard  = (busy[src0] && !w_byp0) || (busy[src1] && !w_byp1);

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter: directed scenarios
//                followed by random traffic compared with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid, m_valid, rsv_valid;
    logic [3:0]  a_dest, m_dest, rsv_dest, src0, src1;
    logic [31:0] a_data, m_data, rd0_in, rd1_in;
    logic        a_ready, m_ready, rf_we, hazard, rsv_err;
    logic [3:0]  rf_dest;
    logic [31:0] rf_data, rd0_out, rd1_out;
    logic [15:0] busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          mdl_alu_first;   // 1: ALU wins a tie
    bit          mdl_we;
    bit [3:0]    mdl_dest;
    bit [31:0]   mdl_data;
    bit          mdl_busy [16];
    bit          mdl_err;

    rf_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_dest(m_dest), .m_data(m_data), .m_ready(m_ready),
        .rsv_valid(rsv_valid), .rsv_dest(rsv_dest),
        .src0(src0), .src1(src1), .rd0_in(rd0_in), .rd1_in(rd1_in),
        .rd0_out(rd0_out), .rd1_out(rd1_out),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
        .busy(busy), .hazard(hazard), .rsv_err(rsv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [1:0] mdl_grants();
        bit ga, gm;
        ga = 1'b0; gm = 1'b0;
        if (!reset) begin
            if (a_valid && m_valid) begin
                ga = mdl_alu_first;
                gm = !mdl_alu_first;
            end else begin
                ga = a_valid;
                gm = m_valid;
            end
        end
        return {ga, gm};
    endfunction

    function automatic bit fwd(input logic [3:0] s);
`ifdef RF_WB_BYPASS_EN
        return mdl_we && (mdl_dest == s);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit [15:0] mdl_busy_vec();
        bit [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = mdl_busy[r];
        return v;
    endfunction

    // Let combinational outputs settle, then compare everything to the model
    task automatic settle();
        bit [1:0]  g;
        bit [31:0] e0, e1;
        bit        hz;
        #1;
        g  = mdl_grants();
        e0 = fwd(src0) ? mdl_data : rd0_in;
        e1 = fwd(src1) ? mdl_data : rd1_in;
        hz = (mdl_busy[src0] && !fwd(src0)) || (mdl_busy[src1] && !fwd(src1));
        check("a_ready", 32'(a_ready), 32'(g[1]));
        check("m_ready", 32'(m_ready), 32'(g[0]));
        check("rf_we",   32'(rf_we),   32'(mdl_we));
        check("rf_dest", 32'(rf_dest), 32'(mdl_dest));
        check("rf_data", rf_data,      mdl_data);
        check("busy",    32'(busy),    32'(mdl_busy_vec()));
        check("hazard",  32'(hazard),  32'(hz));
        check("rsv_err", 32'(rsv_err), 32'(mdl_err));
        check("rd0_out", rd0_out,      e0);
        check("rd1_out", rd1_out,      e1);
    endtask

    // Advance one clock and step the model with the inputs seen at the edge
    task automatic tick();
        bit [1:0] g;
        bit       n_busy [16];
        bit       n_err;
        g = mdl_grants();
        n_err = mdl_err;
        for (int r = 0; r < 16; r++) begin
            n_busy[r] = mdl_busy[r];
            if (mdl_we && mdl_dest == 4'(r)) n_busy[r] = 1'b0;
            if (rsv_valid && rsv_dest == 4'(r)) n_busy[r] = 1'b1;
        end
        if (rsv_valid && mdl_busy[rsv_dest] && !(mdl_we && mdl_dest == rsv_dest))
            n_err = 1'b1;
        @(posedge clk);
        if (reset) begin
            mdl_alu_first = 1'b1;
            mdl_we = 1'b0; mdl_dest = '0; mdl_data = '0; mdl_err = 1'b0;
            for (int r = 0; r < 16; r++) mdl_busy[r] = 1'b0;
        end else begin
            mdl_we = g[1] | g[0];
            if (g[1]) begin
                mdl_dest = a_dest; mdl_data = a_data; mdl_alu_first = 1'b0;
            end else if (g[0]) begin
                mdl_dest = m_dest; mdl_data = m_data; mdl_alu_first = 1'b1;
            end
            mdl_err = n_err;
            for (int r = 0; r < 16; r++) mdl_busy[r] = n_busy[r];
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; a_valid = 1'b0; m_valid = 1'b0; rsv_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        a_dest = '0; a_data = '0; m_dest = '0; m_data = '0; rsv_dest = '0;
        src0 = '0; src1 = '0; rd0_in = '0; rd1_in = '0;
        @(posedge clk); #1;

        // Reset with both requesters valid: no grant during reset
        reset = 1'b1; a_valid = 1'b1; m_valid = 1'b1;
        tick();
        settle();
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        do_reset();

        // Single ALU writeback
        a_valid = 1'b1; a_dest = 4'd3; a_data = 32'hDEADBEEF;
        settle();
        check("wb_a_ready", 32'(a_ready), 32'd1);
        tick(); idle();
        settle();
        check("wb_we", 32'(rf_we), 32'd1);
        check("wb_dest", 32'(rf_dest), 32'd3);
        check("wb_data", rf_data, 32'hDEADBEEF);
        tick(); settle();
        check("wb_we_drop", 32'(rf_we), 32'd0);

        // Contention: alternating grants A, M, A, M
        do_reset();
        a_valid = 1'b1; m_valid = 1'b1;
        a_dest = 4'd1; m_dest = 4'd2; a_data = 32'hA; m_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_a_ready", 32'(a_ready), 32'((i % 2) == 0));
            tick();
            if (i == 3) idle();
            settle();
            check("rr_dest", 32'(rf_dest), (i % 2) == 0 ? 32'd1 : 32'd2);
        end
        tick();

        // Reservation and hazard on reg 5
        do_reset();
        rsv_valid = 1'b1; rsv_dest = 4'd5;
        tick(); idle();
        src0 = 4'd5; src1 = 4'd0;
        settle();
        check("rsv_busy", 32'(busy), 32'h0020);
        check("rsv_hazard", 32'(hazard), 32'd1);
        a_valid = 1'b1; a_dest = 4'd5; a_data = 32'h55;
        tick(); idle();
        settle();
        tick(); settle();
        check("clr_busy", 32'(busy), 32'h0000);
        check("clr_hazard", 32'(hazard), 32'd0);

        // Set beats same-cycle clear; later double reservation is sticky
        do_reset();
        rsv_valid = 1'b1; rsv_dest = 4'd7;
        tick(); idle();
        a_valid = 1'b1; a_dest = 4'd7; a_data = 32'h77;
        tick(); idle();
        rsv_valid = 1'b1; rsv_dest = 4'd7;
        settle();
        tick(); idle();
        settle();
        check("race_busy7", 32'(busy[7]), 32'd1);
        check("race_err", 32'(rsv_err), 32'd0);
        rsv_valid = 1'b1; rsv_dest = 4'd7;
        tick(); idle();
        tick(); tick();
        settle();
        check("dbl_err", 32'(rsv_err), 32'd1);
        do_reset(); settle();
        check("err_rst", 32'(rsv_err), 32'd0);

        // Forwarding window on reg 4
        do_reset();
        rsv_valid = 1'b1; rsv_dest = 4'd4;
        tick(); idle();
        a_valid = 1'b1; a_dest = 4'd4; a_data = 32'h12345678;
        tick(); idle();
        src0 = 4'd0; src1 = 4'd4; rd1_in = 32'd0;
        settle();
`ifdef RF_WB_BYPASS_EN
        check("byp_rd1", rd1_out, 32'h12345678);
        check("byp_hazard", 32'(hazard), 32'd0);
`else
        check("byp_rd1", rd1_out, 32'd0);
        check("byp_hazard", 32'(hazard), 32'd1);
`endif
        tick();

        // Reset coincident with a grant and a reservation
        do_reset();
        a_valid = 1'b1; a_dest = 4'd9; a_data = 32'h99;
        tick();                     // pointer now favours memory
        reset = 1'b1; m_valid = 1'b1; rsv_valid = 1'b1; rsv_dest = 4'd2;
        settle();
        tick(); idle();
        settle();
        check("rg_we", 32'(rf_we), 32'd0);
        check("rg_busy", 32'(busy), 32'd0);
        a_valid = 1'b1; m_valid = 1'b1;
        settle();
        check("rg_ptr_alu", 32'(a_ready), 32'd1);
        tick(); idle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 39) == 0);
            a_valid   = $urandom_range(0, 1);
            m_valid   = $urandom_range(0, 1);
            rsv_valid = ($urandom_range(0, 2) == 0);
            a_dest    = 4'($urandom);
            m_dest    = 4'($urandom);
            rsv_dest  = 4'($urandom);
            a_data    = $urandom;
            m_data    = $urandom;
            src0      = ($urandom_range(0, 1) != 0) ? mdl_dest : 4'($urandom);
            src1      = 4'($urandom);
            rd0_in    = $urandom;
            rd1_in    = $urandom;
            settle();
            tick();
        end
        idle();
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
